// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: time-multiplexed 4-digit hex display scanner.
// Captures a 16-bit value on Load, then steps through the four digits,
// holding each one for TICK_DIV clock cycles. Every output is registered.
// Optional build macro: LEADING_ZERO_BLANK_EN (blanks leading zero digits).
module hex_scan_ctrl #(
   parameter int TICK_DIV = 50000,
   parameter int CNT_W    = 16
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Load,
   input  logic [15:0] DataIn,
   output logic [3:0]  Nibble,
   output logic [3:0]  DigitSel,
   output logic        Blank,
   output logic        Ack,
   output logic        dbg_state
);

   // Load/Ack handshake: Load has no back-pressure. Every rising edge that
   // sees Load=1 captures DataIn into the shadow register, and Ack is high
   // for exactly one cycle on the following edge, the same edge on which
   // Nibble first shows the captured value. Holding Load for M cycles gives
   // M captures and M Ack cycles; the last sample wins.

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

   state_t            state_q, state_d;
   logic [15:0]       shadow_q, shadow_d;
   logic [CNT_W-1:0]  presc_q, presc_d;
   logic [1:0]        idx_q, idx_d;
   logic              load_q;

   logic [3:0]        nibble_d;
   logic [3:0]        sel_d;
   logic              blank_d;
   logic              tick;
   logic [3:0]        cur_nibble;
   logic              lz_blank;

   assign dbg_state = state_q;

   // End of a digit slot: the prescaler has reached its last count.
   assign tick = (state_q == SCAN) && (presc_q == TICK_LAST);

   // Nibble of the shadow register belonging to the current digit index.
   always_comb begin
      cur_nibble = shadow_q[3:0];
      case (idx_q)
         2'd0: cur_nibble = shadow_q[3:0];
         2'd1: cur_nibble = shadow_q[7:4];
         2'd2: cur_nibble = shadow_q[11:8];
         2'd3: cur_nibble = shadow_q[15:12];
         default: cur_nibble = shadow_q[3:0];
      endcase
   end

`ifdef LEADING_ZERO_BLANK_EN
   // A digit above 0 is blanked when it and every digit above it are zero.
   always_comb begin
      lz_blank = 1'b0;
      case (idx_q)
         2'd0: lz_blank = 1'b0;
         2'd1: lz_blank = (shadow_q[15:4] == 12'h000);
         2'd2: lz_blank = (shadow_q[15:8] == 8'h00);
         2'd3: lz_blank = (shadow_q[15:12] == 4'h0);
         default: lz_blank = 1'b0;
      endcase
   end
`else
   // No leading-zero suppression: every digit is lit while scanning.
   assign lz_blank = 1'b0;
`endif

   // Next-state, datapath and next-output decode; defaults first.
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      presc_d  = presc_q;
      idx_d    = idx_q;
      nibble_d = 4'h0;
      sel_d    = 4'b1111;
      blank_d  = 1'b1;

      case (state_q)
         IDLE: begin
            presc_d = '0;
            idx_d   = 2'd0;
            if (Load) begin
               shadow_d = DataIn;
               state_d  = SCAN;
            end
         end
         SCAN: begin
            if (tick) begin
               presc_d = '0;
               idx_d   = idx_q + 2'd1;
            end else begin
               presc_d = presc_q + CNT_W'(1);
            end
            // A capture never disturbs the scan timing.
            if (Load) begin
               shadow_d = DataIn;
            end
            nibble_d = cur_nibble;
            sel_d    = ~(4'b0001 << idx_q);
            blank_d  = lz_blank;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Shadow value, prescaler, digit index and the capture flag behind Ack.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         shadow_q <= 16'h0000;
         presc_q  <= '0;
         idx_q    <= 2'd0;
         load_q   <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         load_q   <= Load;
      end
   end

   // Output registers: one edge behind the scan state they describe.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         Nibble   <= 4'h0;
         DigitSel <= 4'b1111;
         Blank    <= 1'b1;
         Ack      <= 1'b0;
      end else begin
         Nibble   <= nibble_d;
         DigitSel <= sel_d;
         Blank    <= blank_d;
         Ack      <= load_q;
      end
   end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Testbench for hex_scan_ctrl (TICK_DIV=4). A reference model predicts the
// display from elapsed time since the scan started; a monitor compares.
module tb_hex_scan_ctrl;

   localparam int TD = 4;

   logic        Clock;
   logic        Resetn;
   logic        Load;
   logic [15:0] DataIn;
   logic [3:0]  Nibble;
   logic [3:0]  DigitSel;
   logic        Blank;
   logic        Ack;
   logic        dbg_state;

   int checks = 0;
   int errors = 0;

   // Expected {Nibble, DigitSel, Blank, Ack} for the cycle after each edge.
   logic [9:0] exp_q[$];

   hex_scan_ctrl #(.TICK_DIV(TD), .CNT_W(16)) dut (
      .Clock    (Clock),
      .Resetn   (Resetn),
      .Load     (Load),
      .DataIn   (DataIn),
      .Nibble   (Nibble),
      .DigitSel (DigitSel),
      .Blank    (Blank),
      .Ack      (Ack),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // ---------------- reference model ----------------
   // Digit shown j edges after the starting capture is ((j-1)/TD) mod 4.
   bit          m_scan;
   logic [15:0] m_shadow;
   bit          m_ack;
   int          m_edge;
   int          m_start;

   always @(posedge Clock or negedge Resetn) begin
      int         j;
      int         digit;
      logic [3:0] nib;
      logic [3:0] sel;
      logic       blk;
      if (!Resetn) begin
         m_scan   = 1'b0;
         m_shadow = 16'h0000;
         m_ack    = 1'b0;
         m_edge   = 0;
         m_start  = 0;
         exp_q.delete();
      end else begin
         m_edge = m_edge + 1;
         if (!m_scan) begin
            exp_q.push_back({4'h0, 4'b1111, 1'b1, m_ack});
         end else begin
            j     = m_edge - m_start;
            digit = ((j - 1) / TD) % 4;
            nib   = 4'(m_shadow >> (4 * digit));
            sel   = ~(4'b0001 << digit);
            blk   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            if (digit > 0 && (m_shadow >> (4 * digit)) == 16'h0000) blk = 1'b1;
`endif
            exp_q.push_back({nib, sel, blk, m_ack});
         end
         m_ack = Load;
         if (Load) begin
            m_shadow = DataIn;
            if (!m_scan) begin
               m_scan  = 1'b1;
               m_start = m_edge;
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge Clock) begin
      logic [9:0] e;
      logic [9:0] a;
      if (Resetn && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {Nibble, DigitSel, Blank, Ack};
         checks = checks + 1;
         if (a !== e) begin
            errors = errors + 1;
            $display("FAIL scoreboard t=%0t: got nib=%h sel=%b blank=%b ack=%b expected nib=%h sel=%b blank=%b ack=%b",
                     $time, a[9:6], a[5:2], a[1], a[0], e[9:6], e[5:2], e[1], e[0]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge Clock);
   endtask

   // Load held for n cycles; each cycle carries fresh data, the last is d.
   task automatic load_burst(input logic [15:0] d, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge Clock);
         Load   = 1'b1;
         DataIn = (i == n - 1) ? d : 16'($urandom());
      end
      @(negedge Clock);
      Load = 1'b0;
   endtask

   // Asynchronous reset between edges, checked before any further edge.
   task automatic mid_reset();
      @(posedge Clock);
      #2;
      Resetn = 1'b0;
      #1;
      check("async_reset_outputs", {22'h0, Nibble, DigitSel, Blank, Ack}, {22'h0, 4'h0, 4'b1111, 1'b1, 1'b0});
      check("async_reset_state", {31'h0, dbg_state}, 32'h0);
      idle_cycles(2);
      Resetn = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit found;
      Resetn = 1'b0;
      Load   = 1'b0;
      DataIn = 16'h0000;
      repeat (2) @(posedge Clock);
      #1;
      check("reset_outputs", {22'h0, Nibble, DigitSel, Blank, Ack}, {22'h0, 4'h0, 4'b1111, 1'b1, 1'b0});
      check("reset_state", {31'h0, dbg_state}, 32'h0);
      @(negedge Clock);
      Resetn = 1'b1;

      // Idle with no Load: display stays off.
      idle_cycles(10);

      // Single load, then watch a full scan rotation plus wrap.
      load_burst(16'h1234, 1);
      @(negedge Clock);
      check("first_digit", {24'h0, Nibble, DigitSel}, {24'h0, 4'h4, 4'b1110});
      check("first_ack", {31'h0, Ack}, 32'h1);

      // Capture while digit 2 is on; slot timing must not move.
      found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         @(negedge Clock);
         if (DigitSel == 4'b1011) found = 1'b1;
      end
      check("wait_digit2", {31'h0, found}, 32'h1);
      Load   = 1'b1;
      DataIn = 16'hABCD;
      @(negedge Clock);
      Load = 1'b0;
      @(negedge Clock);
      check("scan_load_nibble", {24'h0, Nibble, DigitSel}, {24'h0, 4'hB, 4'b1011});
      idle_cycles(20);

      // Load on the tick edge from digit 0 to digit 1.
      mid_reset();
      idle_cycles(5);
      Load   = 1'b1;
      DataIn = 16'h1234;
      @(negedge Clock);
      Load = 1'b0;
      idle_cycles(3);
      Load   = 1'b1;
      DataIn = 16'hFFFF;
      @(negedge Clock);
      Load = 1'b0;
      @(negedge Clock);
      check("tick_load", {23'h0, Nibble, DigitSel, Ack}, {23'h0, 4'hF, 4'b1101, 1'b1});
      idle_cycles(12);

      // Leading-zero patterns and a held Load.
      load_burst(16'h00A5, 1);
      idle_cycles(18);
      load_burst(16'h0000, 3);
      idle_cycles(18);
      load_burst(16'h0F00, 2);
      idle_cycles(18);

      // Randomized traffic with occasional resets.
      for (int k = 0; k < 60; k++) begin
         idle_cycles($urandom_range(0, 12));
         if ($urandom_range(0, 9) == 0) begin
            mid_reset();
            idle_cycles($urandom_range(0, 5));
         end
         load_burst(16'($urandom()), $urandom_range(1, 3));
      end
      idle_cycles(10);

      @(posedge Clock);
      #1;
      check("queue_depth", exp_q.size(), 32'd1);
      @(negedge Clock);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/hex_scan_ctrl.md
Name: hex_scan_ctrl

Overview:
- Time-multiplexed 4-digit hex display scanner.
- Captures a 16-bit value from the processor bus on a load strobe and holds it.
- Cycles through the four digits at a prescaled rate, presenting one nibble per digit plus an active-low digit select.
- Sits directly upstream of the 7-segment display decoder: its Nibble output drives the decoder's 4-bit input, and its DigitSel output drives the board's common digit enables.

Parameters:
- TICK_DIV, 50000: clock cycles per digit slot. Legal range 2..65535.
- CNT_W, 16: prescaler counter width. Must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- Clock, input, 1: system clock; all state changes on the rising edge.
- Resetn, input, 1: asynchronous, active-low reset.
- Load, input, 1: capture strobe; DataIn is sampled on every rising edge where Load=1.
- DataIn, input, 16: value to display; digit k shows DataIn[4k+3:4k].
- Nibble, output, 4: nibble for the currently selected digit; feeds the display decoder.
- DigitSel, output, 4: one-hot active-low digit enable; bit k low selects digit k.
- Blank, output, 1: 1 means downstream must force all segments off.
- Ack, output, 1: one-cycle pulse on the cycle after each accepted Load.

Behaviour:
- Reset (Resetn=0, immediate, asynchronous):
  - State=IDLE; shadow register=16'h0000; prescaler=0; digit index=0.
  - Outputs: Nibble=4'h0, DigitSel=4'b1111, Blank=1, Ack=0.
- State IDLE:
  - All digits off; prescaler held at 0.
  - Load=1 at edge N: shadow<=DataIn; state<=SCAN; index<=0; prescaler<=0.
  - At edge N+1: DigitSel=4'b1110, Nibble=DataIn[3:0], Blank=0, Ack=1.
- State SCAN:
  - Prescaler counts 0..TICK_DIV-1 and wraps to 0.
  - tick = (prescaler==TICK_DIV-1). On tick, index advances 0->1->2->3->0 (2-bit wrap).
  - All outputs are registered and reflect the new index one edge after the tick edge.
  - Each digit is therefore active for exactly TICK_DIV cycles.
  - DigitSel = ~(4'b0001 << index). Exactly one bit is low at any time in SCAN.
  - Nibble = shadow[4*index+3 : 4*index], re-registered every cycle.
- Load while in SCAN:
  - shadow<=DataIn. Prescaler and index are NOT disturbed.
  - Nibble shows the new value for the current digit one edge after capture.
  - Ack pulses on that same following edge.
- Load held high for M cycles: M captures and M Ack pulses; the last sample wins.
- Load coinciding with tick: both take effect on the same edge. The next edge shows the new index with the new shadow nibble.
- There is no return from SCAN to IDLE except through reset.
- Reset asserted mid-scan: outputs return to reset values immediately, without waiting for a clock edge.
- After reset deasserts, the block stays in IDLE until the next Load.
- No combinational path from any input to any output.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - In SCAN, Blank=1 for any digit k>0 when shadow nibbles k..3 are all zero.
  - Digit 0 is never blanked in SCAN, so 16'h0000 shows a single "0".
  - Example: value 16'h00A5 blanks digits 3 and 2.
  - Blank is registered with the same one-cycle timing as Nibble.
- Undefined: Blank=1 only in IDLE/reset and 0 throughout SCAN. Logic for zero detection is absent.

Test Plan:
1. Reset, then 10 cycles with Load=0 -> DigitSel=4'b1111, Blank=1, Nibble=0, Ack=0 throughout.
2. TICK_DIV=4; Load=1 for one cycle with DataIn=16'h1234 -> next edge: Ack=1, DigitSel=1110, Nibble=4. Each later digit lasts 4 cycles: 1101/3, 1011/2, 0111/1, then wraps to 1110/4.
3. TICK_DIV=4; while digit 2 is active, Load with 16'hABCD -> one edge later Nibble=B, DigitSel=1011 unchanged. Next digit change stays on the original 4-cycle grid and shows A on 0111.
4. TICK_DIV=4; Load asserted on the tick edge from digit 0 to digit 1 with 16'hFFFF after 16'h1234 -> next edge: DigitSel=1101, Nibble=F, Ack=1.
5. Drop Resetn mid-scan between clock edges -> DigitSel=1111, Blank=1, Nibble=0 with no clock edge. After release, remains IDLE until Load.
6. With LEADING_ZERO_BLANK_EN, load 16'h00A5 -> Blank=1 on digits 3 and 2, Blank=0 on digits 1 and 0. Load 16'h0000 -> only digit 0 unblanked, with Nibble=0.
